// File: rtl/mac_pkg.sv
// Shared definitions for the sequential MAC: FSM states, default widths
// and the saturating signed add used when saturation is enabled.
package mac_pkg;

    localparam int unsigned DEFAULT_FEAT_BIT   = 16;
    localparam int unsigned DEFAULT_WEIGHT_BIT = 8;
    localparam int unsigned DEFAULT_OUT_BIT    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        OUT  = 2'd3
    } mac_state_e;

    // Operands must already fit in 'width' signed bits; the wide sum is then
    // equivalent to a width+1 bit overflow check.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        width
    );
        logic signed [63:0] sum;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sum   = a + b;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (sum > max_v) begin
            return max_v;
        end
        if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/seq_mac_shift_add.sv
// Iterative signed multiplier: one weight bit per step, last bit carries
// negative (two's-complement sign) weight.
module seq_mac_shift_add
    import mac_pkg::*;
#(
    parameter int unsigned FEAT_BIT   = DEFAULT_FEAT_BIT,
    parameter int unsigned WEIGHT_BIT = DEFAULT_WEIGHT_BIT
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_start,
    input  logic                                 i_step,
    input  logic signed [FEAT_BIT-1:0]           i_feat,
    input  logic        [WEIGHT_BIT-1:0]         i_weight,
    output logic signed [FEAT_BIT+WEIGHT_BIT-1:0] o_product,
    output logic                                 o_last_c
);

    localparam int unsigned PROD_BIT = FEAT_BIT + WEIGHT_BIT;
    localparam int unsigned CNT_W    = $clog2(WEIGHT_BIT);

    logic signed [FEAT_BIT-1:0] r_feat;
    logic        [WEIGHT_BIT-1:0] r_weight;
    logic        [CNT_W-1:0]    r_cnt;
    logic signed [PROD_BIT-1:0] r_product;

    logic signed [PROD_BIT-1:0] w_feat_ext;
    logic signed [PROD_BIT-1:0] w_term;
    logic                       w_last;

    assign w_last     = (r_cnt == CNT_W'(WEIGHT_BIT - 1));
    assign w_feat_ext = PROD_BIT'(r_feat);
    assign w_term     = r_weight[r_cnt] ? (w_feat_ext <<< r_cnt) : '0;

    // Product register is wide enough that no partial sum can overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_feat    <= '0;
            r_weight  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (i_start) begin
            r_feat    <= i_feat;
            r_weight  <= i_weight;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (i_step) begin
            r_product <= w_last ? (r_product - w_term) : (r_product + w_term);
            r_cnt     <= w_last ? '0 : (r_cnt + CNT_W'(1));
        end
    end

    assign o_product = r_product;
    assign o_last_c  = w_last;

endmodule

// File: rtl/seq_mac_unit.sv
// Sequential signed multiply-accumulate PE with valid/ready on both sides.
// Define SEQ_MAC_SATURATE_EN to clamp the accumulator instead of wrapping.
module seq_mac_unit
    import mac_pkg::*;
#(
    parameter int unsigned FEAT_BIT   = DEFAULT_FEAT_BIT,
    parameter int unsigned WEIGHT_BIT = DEFAULT_WEIGHT_BIT,
    parameter int unsigned OUT_BIT    = DEFAULT_OUT_BIT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [FEAT_BIT-1:0]   in_feat,
    input  logic signed [WEIGHT_BIT-1:0] in_weight,
    input  logic                         in_acc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_BIT-1:0]    out_data
);

    localparam int unsigned PROD_BIT = FEAT_BIT + WEIGHT_BIT;

    mac_state_e r_state;
    mac_state_e w_state_nxt;

    logic                      r_in_ready;
    logic                      r_out_valid;
    logic                      r_acc_en;
    logic signed [OUT_BIT-1:0] r_acc;
    logic signed [OUT_BIT-1:0] r_out_data;

    logic                       w_start;
    logic                       w_step;
    logic                       w_load;
    logic                       w_last;
    logic signed [PROD_BIT-1:0] w_product;
    logic signed [OUT_BIT-1:0]  w_prod_ext;
    logic signed [OUT_BIT-1:0]  w_acc_base;
    logic signed [OUT_BIT-1:0]  w_sum;

    seq_mac_shift_add #(
        .FEAT_BIT   (FEAT_BIT),
        .WEIGHT_BIT (WEIGHT_BIT)
    ) u_shift_add (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_start),
        .i_step    (w_step),
        .i_feat    (in_feat),
        .i_weight  (in_weight),
        .o_product (w_product),
        .o_last_c  (w_last)
    );

    assign w_prod_ext = OUT_BIT'(w_product);
    assign w_acc_base = r_acc_en ? r_acc : '0;

`ifdef SEQ_MAC_SATURATE_EN
    assign w_sum = OUT_BIT'(sat_add(64'(w_acc_base), 64'(w_prod_ext), OUT_BIT));
`else
    assign w_sum = w_acc_base + w_prod_ext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == OUT);
        end
    end

    // Next state and datapath controls.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_step      = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_start     = 1'b1;
                    w_state_nxt = MUL;
                end
            end
            MUL: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = ACC;
                end
            end
            ACC: begin
                w_load      = 1'b1;
                w_state_nxt = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Accumulator persists across operations; only a load or reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_en   <= 1'b0;
            r_acc      <= '0;
            r_out_data <= '0;
        end else begin
            if (w_start) begin
                r_acc_en <= in_acc;
            end
            if (w_load) begin
                r_acc      <= w_sum;
                r_out_data <= w_sum;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_seq_mac_unit.sv
// Self-checking bench for seq_mac_unit: 32-bit and 24-bit accumulator
// instances driven in lockstep and compared against an arithmetic model.
module tb_seq_mac_unit;

    localparam int WB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               in_valid;
    logic               in_acc;
    logic               out_ready;
    logic signed [15:0] in_feat;
    logic signed [7:0]  in_weight;

    logic               in_ready;
    logic               out_valid;
    logic signed [31:0] out_data;
    logic               in_ready24;
    logic               out_valid24;
    logic signed [23:0] out_data24;

    int     checks = 0;
    int     errors = 0;
    longint m_acc32, m_acc24, m_exp32, m_exp24;

    seq_mac_unit u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_feat   (in_feat),
        .in_weight (in_weight),
        .in_acc    (in_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    seq_mac_unit #(.OUT_BIT(24)) u_dut24 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready24),
        .in_feat   (in_feat),
        .in_weight (in_weight),
        .in_acc    (in_acc),
        .out_valid (out_valid24),
        .out_ready (out_ready),
        .out_data  (out_data24)
    );

    // Fit an exact integer into a w-bit signed accumulator.
    function automatic longint fit(input longint v, input int w);
        longint hi, r;
        hi = (longint'(1) <<< (w - 1)) - 1;
`ifdef SEQ_MAC_SATURATE_EN
        if (v > hi)           r = hi;
        else if (v < -hi - 1) r = -hi - 1;
        else                  r = v;
`else
        r = v % (longint'(1) <<< w);
        if (r < 0)  r = r + (longint'(1) <<< w);
        if (r > hi) r = r - (longint'(1) <<< w);
`endif
        return r;
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic issue(input logic signed [15:0] f, input logic signed [7:0] w, input logic a);
        @(negedge clk);
        for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
        chk("in_ready_idle", longint'(in_ready), 1);
        in_valid  = 1'b1;
        in_feat   = f;
        in_weight = w;
        in_acc    = a;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        m_exp32 = fit((a ? m_acc32 : 0) + longint'(f) * longint'(w), 32);
        m_exp24 = fit((a ? m_acc24 : 0) + longint'(f) * longint'(w), 24);
        m_acc32 = m_exp32;
        m_acc24 = m_exp24;
    endtask

    // Cycle 0 is the cycle in which the input handshake is presented.
    task automatic wait_valid(output longint g32, output longint g24);
        int lat;
        lat = -1;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = n + 1;
        end
        chk("latency", lat, WB + 2);
        chk("out_valid24", longint'(out_valid24), 1);
        chk("out_data32", longint'(out_data), m_exp32);
        chk("out_data24", longint'(out_data24), m_exp24);
        g32 = longint'(out_data);
        g24 = longint'(out_data24);
    endtask

    task automatic release_out(input int stall);
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("out_valid_drop", longint'(out_valid), 0);
    endtask

    task automatic run_op(input logic signed [15:0] f, input logic signed [7:0] w, input logic a,
                          input int stall, output longint g32, output longint g24);
        out_ready = (stall == 0);
        issue(f, w, a);
        wait_valid(g32, g24);
        release_out(stall);
    endtask

    typedef struct {
        logic signed [15:0] feat;
        logic signed [7:0]  weight;
        logic               acc;
        longint             exp;
    } vec_t;

    vec_t   vecs[7];
    longint g32, g24;

    initial begin
        vecs[0] = '{-16'sd256,   8'sd127,  1'b0, -32512};
        vecs[1] = '{16'sh8000,   8'sh80,   1'b0, 4194304};
        vecs[2] = '{16'sd32767,  8'sh80,   1'b0, -4194176};
        vecs[3] = '{16'sd100,    8'sd3,    1'b0, 300};
        vecs[4] = '{16'sd50,     -8'sd2,   1'b1, 200};
        vecs[5] = '{16'sd7,      8'sd0,    1'b1, 200};
        vecs[6] = '{16'sd1,      8'sd1,    1'b0, 1};

        rst_n = 1'b0; in_valid = 1'b0; in_feat = '0; in_weight = '0;
        in_acc = 1'b0; out_ready = 1'b1;
        m_acc32 = 0; m_acc24 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_out_data24", longint'(out_data24), 0);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].feat, vecs[i].weight, vecs[i].acc, 0, g32, g24);
            chk($sformatf("vec%0d", i), g32, vecs[i].exp);
        end

        // Backpressure: result held, offered input ignored.
        out_ready = 1'b0;
        issue(16'sd20, 8'sd5, 1'b0);
        wait_valid(g32, g24);
        chk("bp_first", g32, 100);
        @(negedge clk);
        in_valid = 1'b1; in_feat = 16'sd9; in_weight = 8'sd9; in_acc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_data", longint'(out_data), 100);
            chk("bp_hold_valid", longint'(out_valid), 1);
            chk("bp_in_ready", longint'(in_ready), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", longint'(out_valid), 0);
        chk("bp_release_ready", longint'(in_ready), 1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("bp_no_accept", longint'(out_valid), 0);
        end
        run_op(16'sd1, 8'sd1, 1'b1, 0, g32, g24);
        chk("bp_acc_kept", g32, 101);

        // Overflow of the 24-bit accumulator.
        run_op(16'sh8000, 8'sh80, 1'b0, 0, g32, g24);
        chk("ovf_first24", g24, 4194304);
        run_op(16'sh8000, 8'sh80, 1'b1, 0, g32, g24);
        chk("ovf_second32", g32, 8388608);
`ifdef SEQ_MAC_SATURATE_EN
        chk("ovf_second24", g24, 8388607);
`else
        chk("ovf_second24", g24, -8388608);
`endif

        // Reset during MUL discards the operation and clears the accumulator.
        out_ready = 1'b1;
        issue(16'sd3, 8'sd3, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_acc32 = 0; m_acc24 = 0;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", longint'(in_ready), 1);
        chk("midrst_out_valid_after", longint'(out_valid), 0);
        chk("midrst_out_data", longint'(out_data), 0);
        run_op(16'sd2, 8'sd2, 1'b1, 0, g32, g24);
        chk("midrst_next", g32, 4);

        // Random operands, accumulate flags and output stalls.
        for (int i = 0; i < 40; i++) begin
            run_op(16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), g32, g24);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
